// File: rtl/register_file_sb.sv
// register_file_sb
//   DEPTH x DATA_W register file (DEPTH = 2**ADDR_W) with two combinational
//   read ports, one synchronous write port and a per-entry busy scoreboard.
//   Decode reserves an entry (marks it busy) and writeback writes and releases
//   it. ZERO_REG hardwires entry 0 to zero. BYPASS forwards same-cycle write
//   data and write-release to the read side.
// Ports
//   clk                  rising-edge clock
//   rst                  asynchronous reset, active-low
//   addr_a/addr_b        read addresses; data_a/data_b read data (comb.)
//   w_en/addr_c/data_c   write port; a write clears the entry's busy bit
//   rsv_en/rsv_addr      reserve request: mark rsv_addr busy
//   rsv_ok               reservation would be accepted this cycle
//   busy_a/busy_b        effective busy state of addr_a/addr_b
//   busy_cnt             registered count of busy entries
module register_file_sb #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] addr_c,
  input  logic [DATA_W-1:0] data_c,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  output logic              busy_a,
  output logic              busy_b,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_busy_cnt;

  logic w_zero_a, w_zero_b, w_zero_c, w_zero_r;
  logic w_hit_a, w_hit_b;
  logic w_wr, w_rsv;
  logic w_inc, w_dec;

  assign w_zero_a = ZERO_REG && (addr_a == '0);
  assign w_zero_b = ZERO_REG && (addr_b == '0);
  assign w_zero_c = ZERO_REG && (addr_c == '0);
  assign w_zero_r = ZERO_REG && (rsv_addr == '0);

  // A write to the hardwired-zero entry never hits a read port.
  assign w_hit_a = w_en && (addr_c == addr_a) && !w_zero_a;
  assign w_hit_b = w_en && (addr_c == addr_b) && !w_zero_b;

  assign data_a = (BYPASS && w_hit_a) ? data_c : r_mem[addr_a];
  assign data_b = (BYPASS && w_hit_b) ? data_c : r_mem[addr_b];

  // With bypass, a same-cycle write already supplies the result, so the entry
  // is not reported busy to the reader.
  assign busy_a = r_busy[addr_a] && !(BYPASS && w_hit_a) && !w_zero_a;
  assign busy_b = r_busy[addr_b] && !(BYPASS && w_hit_b) && !w_zero_b;

  // Reserving an entry that is being released this cycle is allowed.
  assign rsv_ok = !r_busy[rsv_addr] || (w_en && (addr_c == rsv_addr));

  assign w_wr  = w_en && !w_zero_c;
  assign w_rsv = rsv_en && rsv_ok && !w_zero_r;

  // Counter delta mirrors the busy-bit transitions: a reserve only adds when
  // the entry was idle (a busy entry can only be re-reserved together with its
  // release, net zero); a write only subtracts when it actually clears a busy
  // bit that is not re-set by a same-entry reserve.
  assign w_inc = w_rsv && !r_busy[rsv_addr];
  assign w_dec = w_wr && r_busy[addr_c] && !(w_rsv && (rsv_addr == addr_c));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[addr_c] <= data_c;
    end
  end

  // Set is scheduled after clear so a same-entry reserve wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      if (w_wr) begin
        r_busy[addr_c] <= 1'b0;
      end
      if (w_rsv) begin
        r_busy[rsv_addr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy_cnt <= '0;
    end else begin
      unique case ({w_inc, w_dec})
        2'b10:   r_busy_cnt <= r_busy_cnt + (ADDR_W + 1)'(1);
        2'b01:   r_busy_cnt <= r_busy_cnt - (ADDR_W + 1)'(1);
        default: r_busy_cnt <= r_busy_cnt;
      endcase
    end
  end

  assign busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;

  logic        clk;
  logic        rst;
  logic [3:0]  addr_a, addr_b, addr_c, rsv_addr;
  logic        w_en, rsv_en;
  logic [15:0] data_c;

  logic [15:0] data_a, data_b;
  logic        rsv_ok, busy_a, busy_b;
  logic [4:0]  busy_cnt;

  logic [15:0] nb_data_a, nb_data_b;
  logic        nb_rsv_ok, nb_busy_a, nb_busy_b;
  logic [4:0]  nb_busy_cnt;

  register_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .addr_a(addr_a), .addr_b(addr_b),
    .data_a(data_a), .data_b(data_b),
    .w_en(w_en), .addr_c(addr_c), .data_c(data_c),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .busy_a(busy_a), .busy_b(busy_b), .busy_cnt(busy_cnt)
  );

  // Same stimulus, no forwarding: state is identical, only read-side differs.
  register_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst),
    .addr_a(addr_a), .addr_b(addr_b),
    .data_a(nb_data_a), .data_b(nb_data_b),
    .w_en(w_en), .addr_c(addr_c), .data_c(data_c),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(nb_rsv_ok),
    .busy_a(nb_busy_a), .busy_b(nb_busy_b), .busy_cnt(nb_busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] da, db, da2, db2;
    logic        ba, bb, ba2, bb2, rok;
    logic [4:0]  cnt;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_mem [16];
  logic        m_busy [16];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] m_count();
    logic [4:0] c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'b0, m_busy[i]};
    return c;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    logic hit_a, hit_b;
    hit_a = w_en && (addr_c == addr_a) && (addr_a != 4'd0);
    hit_b = w_en && (addr_c == addr_b) && (addr_b != 4'd0);
    e.da  = hit_a ? data_c : m_mem[addr_a];
    e.db  = hit_b ? data_c : m_mem[addr_b];
    e.da2 = m_mem[addr_a];
    e.db2 = m_mem[addr_b];
    e.ba  = m_busy[addr_a] && !hit_a;
    e.bb  = m_busy[addr_b] && !hit_b;
    e.ba2 = m_busy[addr_a];
    e.bb2 = m_busy[addr_b];
    e.rok = !m_busy[rsv_addr] || (w_en && (addr_c == rsv_addr));
    e.cnt = m_count();
    return e;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic m_edge();
    logic ok;
    ok = !m_busy[rsv_addr] || (w_en && (addr_c == rsv_addr));
    if (w_en && addr_c != 4'd0) begin
      m_mem[addr_c]  = data_c;
      m_busy[addr_c] = 1'b0;
    end
    if (rsv_en && ok && rsv_addr != 4'd0) m_busy[rsv_addr] = 1'b1;
  endtask

  // Push the prediction for the current inputs, let outputs settle, compare.
  task automatic check_now(input string tag);
    exp_t e;
    q.push_back(predict());
    #2;
    e = q.pop_front();
    chk({tag, ".data_a"},   32'(data_a),      32'(e.da));
    chk({tag, ".data_b"},   32'(data_b),      32'(e.db));
    chk({tag, ".busy_a"},   32'(busy_a),      32'(e.ba));
    chk({tag, ".busy_b"},   32'(busy_b),      32'(e.bb));
    chk({tag, ".rsv_ok"},   32'(rsv_ok),      32'(e.rok));
    chk({tag, ".busy_cnt"}, 32'(busy_cnt),    32'(e.cnt));
    chk({tag, ".nb_data_a"}, 32'(nb_data_a),  32'(e.da2));
    chk({tag, ".nb_data_b"}, 32'(nb_data_b),  32'(e.db2));
    chk({tag, ".nb_busy_a"}, 32'(nb_busy_a),  32'(e.ba2));
    chk({tag, ".nb_busy_b"}, 32'(nb_busy_b),  32'(e.bb2));
    chk({tag, ".nb_cnt"},   32'(nb_busy_cnt), 32'(e.cnt));
  endtask

  task automatic cycle(input string tag, input logic we, input logic [3:0] ac,
                       input logic [15:0] dc, input logic re, input logic [3:0] ra,
                       input logic [3:0] aa, input logic [3:0] ab);
    @(negedge clk);
    w_en = we; addr_c = ac; data_c = dc;
    rsv_en = re; rsv_addr = ra; addr_a = aa; addr_b = ab;
    check_now(tag);
    @(posedge clk);
    m_edge();
  endtask

  initial begin
    rst = 1'b0; w_en = 1'b0; rsv_en = 1'b0;
    addr_a = '0; addr_b = '0; addr_c = '0; rsv_addr = '0; data_c = '0;
    m_reset();
    #2;
    check_now("reset");
    @(negedge clk);
    rst = 1'b1;

    // true write enable
    cycle("wen0",   1'b0, 4'd5, 16'hBEEF, 1'b0, 4'd0, 4'd5, 4'd5);
    cycle("wen1",   1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 4'd5, 4'd1);
    cycle("rd5",    1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd5, 4'd5);
    // same-cycle forwarding
    cycle("byp3",   1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 4'd3, 4'd5);
    cycle("rd3",    1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd3, 4'd3);
    // hardwired zero
    cycle("zero",   1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 4'd0, 4'd0);
    cycle("zerord", 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd0);
    // reserve / WAW block / release
    cycle("rsv7",   1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd7, 4'd7);
    cycle("rsv7b",  1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd7, 4'd0);
    cycle("wr7",    1'b1, 4'd7, 16'h0777, 1'b0, 4'd0, 4'd7, 4'd7);
    cycle("rd7",    1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd7, 4'd7);
    // same-entry write + reserve on a busy entry
    cycle("rsv9",   1'b0, 4'd0, 16'h0000, 1'b1, 4'd9, 4'd9, 4'd9);
    cycle("wrrsv9", 1'b1, 4'd9, 16'h9999, 1'b1, 4'd9, 4'd9, 4'd9);
    cycle("rd9",    1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd9, 4'd9);
    // write + reserve on different entries
    cycle("wr9r4",  1'b1, 4'd9, 16'hAAAA, 1'b1, 4'd4, 4'd9, 4'd4);
    cycle("rd94",   1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd9, 4'd4);

    for (int i = 0; i < 200; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 4'($urandom));
    end

    for (int i = 1; i < 16; i++) begin
      cycle("rsvall", 1'b0, 4'd0, 16'h0000, 1'b1, 4'(i), 4'(i), 4'd0);
    end
    cycle("full", 1'b0, 4'd0, 16'h0000, 1'b1, 4'd1, 4'd15, 4'd1);
    chk("full.cnt15", 32'(busy_cnt), 32'd15);

    // asynchronous reset in the middle of a low phase, entries dirty
    for (int i = 1; i < 16; i++) begin
      cycle("dirty", 1'b1, 4'(i), 16'(16'h1000 + i), 1'b0, 4'd0, 4'(i), 4'd0);
    end
    @(negedge clk);
    w_en = 1'b0; rsv_en = 1'b0; addr_a = 4'd3; addr_b = 4'd15;
    #1;
    rst = 1'b0;
    m_reset();
    check_now("midrst");
    chk("midrst.zero_a", 32'(data_a), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cycle("post", 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd3, 4'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
